// File: rtl/bloco_controle_pkg.sv
// Shared definitions for the polynomial control unit: state encoding,
// ULA op codes, datapath mux select codes and the Moore output decode.
package bloco_controle_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LOAD = 4'd1,
    S_H1   = 4'd2,
    S_H2   = 4'd3,
    S_H3   = 4'd4,
    S_H4   = 4'd5,
    S_D1   = 4'd6,
    S_D2   = 4'd7,
    S_D3   = 4'd8,
    S_D4   = 4'd9,
    S_D5   = 4'd10,
    S_DONE = 4'd11
  } state_t;

  // Default ULA op codes (the top can remap them via parameters)
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  // mux0 constant select: 0/1 a, 2 b, 3 c
  localparam logic [1:0] M0_A = 2'd0;
  localparam logic [1:0] M0_B = 2'd2;
  localparam logic [1:0] M0_C = 2'd3;
  // ULA operand B (m1): 0 mux0, 1 X, 2 S, 3 H
  localparam logic [1:0] M1_M0 = 2'd0;
  localparam logic [1:0] M1_X  = 2'd1;
  localparam logic [1:0] M1_H  = 2'd3;
  // ULA operand A (m2): 0 X, 1 mux0, 2 S, 3 H
  localparam logic [1:0] M2_X = 2'd0;
  localparam logic [1:0] M2_S = 2'd2;
  localparam logic [1:0] M2_H = 2'd3;

  // Registered control word; mul selects multiply, otherwise add
  typedef struct packed {
    logic       ready;
    logic       done;
    logic       lx;
    logic       ls;
    logic       lh;
    logic       mul;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
  } ctrl_t;

  function automatic logic is_op(state_t s);
    return s inside {S_H1, S_H2, S_H3, S_H4, S_D1, S_D2, S_D3, S_D4, S_D5};
  endfunction

  function automatic state_t first_op(logic direct);
    return direct ? S_D1 : S_H1;
  endfunction

  function automatic state_t next_op(state_t s);
    state_t n;
    case (s)
      S_H1:    n = S_H2;
      S_H2:    n = S_H3;
      S_H3:    n = S_H4;
      S_H4:    n = S_DONE;
      S_D1:    n = S_D2;
      S_D2:    n = S_D3;
      S_D3:    n = S_D4;
      S_D4:    n = S_D5;
      S_D5:    n = S_DONE;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  // Output word for state s; strobe is the load pulse of the op (cnt==0).
  // Selects not used by an op are left at 0.
  function automatic ctrl_t decode(state_t s, logic strobe);
    ctrl_t c;
    c = '0;
    case (s)
      S_IDLE: c.ready = 1'b1;
      S_LOAD: c.lx = 1'b1;
      S_H1: begin c.m2 = M2_X; c.m0 = M0_A; c.m1 = M1_M0; c.mul = 1'b1; c.ls = strobe; end
      S_H2: begin c.m2 = M2_S; c.m0 = M0_B; c.m1 = M1_M0;               c.ls = strobe; end
      S_H3: begin c.m2 = M2_S;              c.m1 = M1_X;  c.mul = 1'b1; c.ls = strobe; end
      S_H4: begin c.m2 = M2_S; c.m0 = M0_C; c.m1 = M1_M0;               c.ls = strobe; end
      S_D1: begin c.m2 = M2_X;              c.m1 = M1_X;  c.mul = 1'b1; c.lh = strobe; end
      S_D2: begin c.m2 = M2_H; c.m0 = M0_A; c.m1 = M1_M0; c.mul = 1'b1; c.lh = strobe; end
      S_D3: begin c.m2 = M2_X; c.m0 = M0_B; c.m1 = M1_M0; c.mul = 1'b1; c.ls = strobe; end
      S_D4: begin c.m2 = M2_S;              c.m1 = M1_H;                c.ls = strobe; end
      S_D5: begin c.m2 = M2_S; c.m0 = M0_C; c.m1 = M1_M0;               c.ls = strobe; end
      S_DONE: c.done = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bloco_controle_if.sv
// Handshake and datapath control bundle between the host/datapath side and
// the control unit.
interface bloco_controle_if;
  logic       start;
  logic       modo;
  logic       ready;
  logic       done;
  logic       h;
  logic       LX;
  logic       LS;
  logic       LH;
  logic [1:0] m0;
  logic [1:0] m1;
  logic [1:0] m2;

  modport master (
    output start, modo,
    input  ready, done, h, LX, LS, LH, m0, m1, m2
  );

  modport slave (
    input  start, modo,
    output ready, done, h, LX, LS, LH, m0, m1, m2
  );
endinterface

// File: rtl/bloco_controle_espera.sv
// contador_espera: loadable down-counter with zero flag; paces each ULA op.
module contador_espera
  import bloco_controle_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  // load wins; otherwise count down while enabled, sticking at zero
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)          cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (en && !zero) cnt <= cnt - W'(1);
  end

endmodule

// File: rtl/bloco_controle.sv
// bloco_controle: sequences the polynomial datapath to evaluate
// y = a*x^2 + b*x + c, in Horner form (4 ops) or direct form via Reg_H (5 ops).
// Each ULA op holds its selects for ULA_LAT cycles and strobes its load in the
// last one. All outputs are registered from the next state.
module bloco_controle
  import bloco_controle_pkg::*;
#(
  parameter int   ULA_LAT = 1,
  parameter logic H_ADD   = OP_ADD,
  parameter logic H_MUL   = OP_MUL
) (
  input logic             clock,
  input logic             resetn,
  bloco_controle_if.slave bus
);

  localparam int            CW     = $clog2(ULA_LAT) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(ULA_LAT - 1);
  // with a single-cycle ULA the strobe is already due on op entry
  localparam logic          STROBE_ON_ENTRY = (ULA_LAT == 1);

  state_t        state;
  logic          modo_r;
  ctrl_t         ctl;
  logic [CW-1:0] cnt;
  logic          zero;
  logic          cnt_load;
  logic          cnt_en;

  // reload on LOAD and on every op hand-over; count only inside ops
  assign cnt_en   = is_op(state);
  assign cnt_load = (state == S_LOAD) || (cnt_en && zero);

  contador_espera #(.W(CW)) u_espera (
    .clock    (clock),
    .resetn   (resetn),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (RELOAD),
    .cnt      (cnt),
    .zero     (zero)
  );

  // sequencer: next state plus the control word that goes with it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      modo_r <= 1'b0;
      ctl    <= decode(S_IDLE, 1'b0);
    end else begin
      case (state)
        S_IDLE:
          if (bus.start) begin
            state  <= S_LOAD;
            modo_r <= bus.modo;
            ctl    <= decode(S_LOAD, 1'b0);
          end
        S_LOAD: begin
          state <= first_op(modo_r);
          ctl   <= decode(first_op(modo_r), STROBE_ON_ENTRY);
        end
        S_H1, S_H2, S_H3, S_H4, S_D1, S_D2, S_D3, S_D4, S_D5:
          if (zero) begin
            state <= next_op(state);
            ctl   <= decode(next_op(state), STROBE_ON_ENTRY);
          end else begin
            // counter reaches zero next cycle -> raise the load strobe then
            ctl <= decode(state, cnt == CW'(1));
          end
        S_DONE: begin
          state <= S_IDLE;
          ctl   <= decode(S_IDLE, 1'b0);
        end
        default: begin
          state <= S_IDLE;
          ctl   <= decode(S_IDLE, 1'b0);
        end
      endcase
    end
  end

  assign bus.ready = ctl.ready;
  assign bus.done  = ctl.done;
  assign bus.LX    = ctl.lx;
  assign bus.LS    = ctl.ls;
  assign bus.LH    = ctl.lh;
  assign bus.h     = ctl.mul ? H_MUL : H_ADD;
  assign bus.m0    = ctl.m0;
  assign bus.m1    = ctl.m1;
  assign bus.m2    = ctl.m2;

  // register loads are mutually exclusive
  a_loads_onehot: assert property (@(posedge clock) disable iff (!resetn)
    $onehot0({bus.LX, bus.LS, bus.LH}));

  // nothing is loaded or reported while idle
  a_idle_quiet: assert property (@(posedge clock) disable iff (!resetn)
    bus.ready |-> !(bus.LX || bus.LS || bus.LH || bus.done));

endmodule
